kmeans_cfg_regfile: RTL and testbench
=====================================

Name: kmeans_cfg_regfile

Overview:
Parametrised APB-slave configuration/status register file for the k-means accelerator, successor to the fixed 8-centroid register file. Sits between the host APB bus and the k-means core. Holds NUM_CENT centroids, RAM window and threshold registers. Adds a run/done/interrupt state machine, one-wait-state APB with pslverr, a W1C interrupt flag, and a handshaked core register port.

Parameters:
ADDR_W, 9, APB address width and RAM address width
DATA_W, 91, register/data width
NUM_CENT, 8, centroid register count (1..16)
MAN_W, 16, Manhattan threshold width
IDX_W, 5, core register-index width (must hold 8+NUM_CENT-1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
paddr  in  ADDR_W  APB address
psel, penable, pwrite  in  1  APB control
pwdata  in  DATA_W  APB write data
prdata  out  DATA_W  APB read data
pready  out  1  APB ready
pslverr  out  1  APB error
core_done  in  1  core completion pulse
core_rd_en  in  1  core register read request
core_wr_en  in  1  core register write request
core_idx  in  IDX_W  core register index
core_wdata  in  DATA_W  core write data
core_rdata  out  DATA_W  core read data
core_rvalid  out  1  core_rdata valid
go_core  out  1  one-cycle start pulse
irq  out  1  level interrupt to host
ram_cs_n, ram_we_n  out  1  RAM strobes, active low
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
first_addr, last_addr  out  ADDR_W  RAM window
threshold  out  MAN_W  Manhattan threshold

Behaviour:
- Register map (word index = paddr): 0 STATUS RO {irq_pend, state[1:0]}; 1 CTRL bit0 GO (write-1 start, reads 0); 2 RAM_ADDR; 3 RAM_DATA; 4 FIRST_ADDR; 5 LAST_ADDR; 6 THRESH; 7 IRQ (bit0 W1C); 8..8+NUM_CENT-1 CENT[i]. Narrow registers are zero-extended on read.
- Reset: all registers, prdata, core_rdata and STATUS are 0. pready, pslverr, go_core, irq and core_rvalid are 0. ram_cs_n and ram_we_n are 1. Run FSM is IDLE.
- APB FSM: IDLE -> WAIT on psel & penable. WAIT -> RESP: the access executes, and pready=1 for exactly one cycle with prdata/pslverr valid. RESP -> IDLE. Every transfer has exactly one wait state. psel dropping in WAIT aborts to IDLE with no side effect.
- pslverr=1 (write suppressed, prdata=0) for: unmapped address; write to STATUS; any write except IRQ while state≠IDLE.
- Run FSM: IDLE -> RUN on an accepted GO=1 write. go_core=1 on the following cycle only.
- RUN -> DONE on core_done. DONE sets irq_pend, and irq = irq_pend.
- DONE -> IDLE when IRQ bit0 is written with 1; this also clears irq_pend.
- core_done in IDLE or DONE: ignored.
- GO written in DONE: pslverr.
- RAM write: an accepted APB write to RAM_DATA in IDLE drives ram_cs_n=ram_we_n=0 for one cycle, on the cycle after RESP. ram_addr and ram_wdata hold their register values. No other path touches the RAM strobes.
- Core port: active only in RUN, ignored otherwise.
- Core read: core_rd_en -> core_rvalid=1 next cycle, with core_rdata = register[core_idx]. An unmapped index returns 0.
- Core write: core_wr_en writes CENT[core_idx-8] only; any other index is ignored.
- core_rd_en and core_wr_en together: write takes effect and read returns the old value.
- APB reads during RUN are serviced normally. A centroid read in the same cycle as a core write returns the old value.
- Reset asserted mid-transfer or mid-run returns everything to its reset values immediately.

Optional Feature:
KMEANS_RF_PERF_CNT_EN: adds RO register index 8+NUM_CENT, PERF, 32-bit.
- Cleared on the IDLE->RUN transition.
- Increments every RUN cycle, saturating at 2^32-1.
- Frozen in DONE.
Without the macro, that index is unmapped and returns pslverr.

Decomposition:
Package kmeans_rf_pkg holds:
- register-index localparams/enum
- run-state enum {IDLE, RUN, DONE}
- STATUS bit positions
Natural sub-module: kmeans_rf_apb_if (APB wait-state FSM producing a one-cycle access strobe plus pready/pslverr timing). The register array and run FSM stay in the top.

Test Plan:
- Write CENT[3]=91'h5A5, read back -> pready after exactly 1 wait state, prdata=91'h5A5, pslverr=0.
- Write paddr=0x1F0 -> pslverr=1; write STATUS -> pslverr=1, STATUS unchanged.
- Write RAM_ADDR=0x12, then RAM_DATA=0x77 -> one cycle ram_cs_n=ram_we_n=0 with ram_addr=0x12, ram_wdata=0x77.
- GO=1 -> go_core pulses 1 cycle, STATUS=RUN. THRESH write -> pslverr. core_wr_en idx=9, data=0xABC -> CENT[1] reads 0xABC.
- core_done -> irq=1, STATUS=DONE. IRQ write 1 -> irq=0, STATUS=IDLE. With KMEANS_RF_PERF_CNT_EN and 40 RUN cycles, PERF reads 40.
- Assert rst_n=0 mid-RUN while in APB WAIT -> all outputs at reset values, next transfer completes normally.

Source files
------------

// File: rtl/kmeans_rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : kmeans_rf_pkg
//  Brief    : Shared register indices, STATUS bit positions and state
//             encodings for the k-means configuration register file.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
package kmeans_rf_pkg;

  // Register word indices (word index == paddr)
  localparam int unsigned REG_STATUS   = 0;
  localparam int unsigned REG_CTRL     = 1;
  localparam int unsigned REG_RAM_ADDR = 2;
  localparam int unsigned REG_RAM_DATA = 3;
  localparam int unsigned REG_FIRST    = 4;
  localparam int unsigned REG_LAST     = 5;
  localparam int unsigned REG_THRESH   = 6;
  localparam int unsigned REG_IRQ      = 7;
  localparam int unsigned REG_CENT0    = 8;

  // STATUS layout: {irq_pend, state[1:0]}
  localparam int unsigned STAT_STATE_LSB = 0;
  localparam int unsigned STAT_IRQ_BIT   = 2;

  // Run state machine; encoding is visible to the host through STATUS
  typedef enum logic [1:0] {
    RUN_IDLE = 2'd0,
    RUN_BUSY = 2'd1,
    RUN_DONE = 2'd2
  } run_state_e;

  // APB wait-state machine
  typedef enum logic [1:0] {
    APB_IDLE = 2'd0,
    APB_WAIT = 2'd1,
    APB_RESP = 2'd2
  } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/kmeans_rf_apb_if.sv
`default_nettype none
// ============================================================================
//  Module   : kmeans_rf_apb_if
//  Brief    : APB slave timing with exactly one wait state. Emits a one-cycle
//             access strobe in WAIT and presents the captured read data and
//             error flag together with pready during RESP.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
import kmeans_rf_pkg::*;

module kmeans_rf_apb_if #(
  parameter int DATA_W = 91
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic [DATA_W-1:0] rdata_in,
  input  logic              err_in,
  output logic              access,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr
);

  apb_state_e state, state_nx;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= APB_IDLE;
    else        state <= state_nx;
  end

  // Next state; the access executes only if psel is still held in WAIT
  always_comb begin
    state_nx = state;
    access   = 1'b0;
    case (state)
      APB_IDLE: if (psel && penable) state_nx = APB_WAIT;
      APB_WAIT: begin
        if (psel) begin
          access   = 1'b1;
          state_nx = APB_RESP;
        end else begin
          state_nx = APB_IDLE;
        end
      end
      APB_RESP: state_nx = APB_IDLE;
      default:  state_nx = APB_IDLE;
    endcase
  end

  assign pready = (state == APB_RESP);

  // Response capture: loaded by the access, cleared once RESP is over
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prdata  <= '0;
      pslverr <= 1'b0;
    end else if (access) begin
      prdata  <= rdata_in;
      pslverr <= err_in;
    end else begin
      prdata  <= '0;
      pslverr <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/kmeans_cfg_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : kmeans_cfg_regfile
//  Brief    : APB configuration/status register file for the k-means core:
//             centroids, RAM window, threshold, run/done/irq state machine,
//             APB-driven RAM write strobe and a core-side register port.
//  Options  : KMEANS_RF_PERF_CNT_EN adds a 32-bit RO PERF register at index
//             8+NUM_CENT counting RUN cycles (saturating).
//  Revision : 1.0 - initial parametrised release
// ============================================================================
import kmeans_rf_pkg::*;

module kmeans_cfg_regfile #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 91,
  parameter int NUM_CENT = 8,
  parameter int MAN_W    = 16,
  parameter int IDX_W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic              core_done,
  input  logic              core_rd_en,
  input  logic              core_wr_en,
  input  logic [IDX_W-1:0]  core_idx,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  output logic              go_core,
  output logic              irq,
  output logic              ram_cs_n,
  output logic              ram_we_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] first_addr,
  output logic [ADDR_W-1:0] last_addr,
  output logic [MAN_W-1:0]  threshold
);

`ifdef KMEANS_RF_PERF_CNT_EN
  localparam int unsigned REG_PERF = REG_CENT0 + NUM_CENT;
  localparam int unsigned NUM_REGS = REG_CENT0 + NUM_CENT + 1;
  logic [31:0] perf_cnt;
`else
  localparam int unsigned NUM_REGS = REG_CENT0 + NUM_CENT;
`endif

  run_state_e        state, state_nx;
  logic              irq_pend;
  logic [DATA_W-1:0] cent [NUM_CENT];
  logic              ram_pend;

  logic              access;
  logic [31:0]       apb_idx;
  logic [31:0]       core_ix;
  logic              apb_err;
  logic [DATA_W-1:0] apb_rdata;
  logic              wr_ok;
  logic              go_accept;
  logic              irq_clr;
  logic              core_en;

  assign apb_idx = 32'(paddr);
  assign core_ix = 32'(core_idx);
  assign core_en = (state == RUN_BUSY);
  assign irq     = irq_pend;

  // Register read mux shared by the APB and core ports; narrow fields zero-extended
  function automatic logic [DATA_W-1:0] reg_value(input logic [31:0] idx);
    logic [DATA_W-1:0] v;
    v = '0;
    case (idx)
      REG_STATUS: begin
        v[STAT_IRQ_BIT]                   = irq_pend;
        v[STAT_STATE_LSB+1:STAT_STATE_LSB] = state;
      end
      REG_RAM_ADDR: v[ADDR_W-1:0] = ram_addr;
      REG_RAM_DATA: v             = ram_wdata;
      REG_FIRST:    v[ADDR_W-1:0] = first_addr;
      REG_LAST:     v[ADDR_W-1:0] = last_addr;
      REG_THRESH:   v[MAN_W-1:0]  = threshold;
      REG_IRQ:      v[0]          = irq_pend;
      default:      v             = '0;
    endcase
    for (int i = 0; i < NUM_CENT; i++) begin
      if (idx == 32'(REG_CENT0 + i)) v = cent[i];
    end
`ifdef KMEANS_RF_PERF_CNT_EN
    if (idx == REG_PERF) v[31:0] = perf_cnt;
`endif
    return v;
  endfunction

  kmeans_rf_apb_if #(.DATA_W(DATA_W)) u_apb_if (
    .clk      (clk),
    .rst_n    (rst_n),
    .psel     (psel),
    .penable  (penable),
    .rdata_in (apb_rdata),
    .err_in   (apb_err),
    .access   (access),
    .pready   (pready),
    .prdata   (prdata),
    .pslverr  (pslverr)
  );

  // Access legality and read data; errored or write accesses return zero
  always_comb begin
    apb_err = (apb_idx >= NUM_REGS);
    if (pwrite) begin
      if (apb_idx == REG_STATUS) apb_err = 1'b1;
`ifdef KMEANS_RF_PERF_CNT_EN
      if (apb_idx == REG_PERF) apb_err = 1'b1;
`endif
      // Outside IDLE only the IRQ acknowledge may be written
      if (state != RUN_IDLE && apb_idx != REG_IRQ) apb_err = 1'b1;
    end
    apb_rdata = (apb_err || pwrite) ? '0 : reg_value(apb_idx);
    wr_ok     = access && pwrite && !apb_err;
    go_accept = wr_ok && (apb_idx == REG_CTRL) && pwdata[0];
    irq_clr   = wr_ok && (apb_idx == REG_IRQ)  && pwdata[0];
  end

  // Run state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN_IDLE;
    else        state <= state_nx;
  end

  // Run next-state: core_done only matters in RUN, acknowledge only in DONE
  always_comb begin
    state_nx = state;
    case (state)
      RUN_IDLE: if (go_accept) state_nx = RUN_BUSY;
      RUN_BUSY: if (core_done) state_nx = RUN_DONE;
      RUN_DONE: if (irq_clr)   state_nx = RUN_IDLE;
      default:  state_nx = RUN_IDLE;
    endcase
  end

  // Host-writable configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr   <= '0;
      ram_wdata  <= '0;
      first_addr <= '0;
      last_addr  <= '0;
      threshold  <= '0;
    end else if (wr_ok) begin
      case (apb_idx)
        REG_RAM_ADDR: ram_addr   <= pwdata[ADDR_W-1:0];
        REG_RAM_DATA: ram_wdata  <= pwdata;
        REG_FIRST:    first_addr <= pwdata[ADDR_W-1:0];
        REG_LAST:     last_addr  <= pwdata[ADDR_W-1:0];
        REG_THRESH:   threshold  <= pwdata[MAN_W-1:0];
        default:      ;
      endcase
    end
  end

  // Centroids: APB writes in IDLE, core writes in RUN (never both at once)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CENT; i++) cent[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CENT; i++) begin
        if (wr_ok && apb_idx == 32'(REG_CENT0 + i))
          cent[i] <= pwdata;
        else if (core_en && core_wr_en && core_ix == 32'(REG_CENT0 + i))
          cent[i] <= core_wdata;
      end
    end
  end

  // Interrupt pending flag, start pulse and delayed RAM write strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_pend <= 1'b0;
      go_core  <= 1'b0;
      ram_pend <= 1'b0;
      ram_cs_n <= 1'b1;
      ram_we_n <= 1'b1;
    end else begin
      if (state == RUN_BUSY && core_done) irq_pend <= 1'b1;
      else if (irq_clr)                   irq_pend <= 1'b0;
      go_core  <= go_accept;
      ram_pend <= wr_ok && (apb_idx == REG_RAM_DATA);
      ram_cs_n <= !ram_pend;
      ram_we_n <= !ram_pend;
    end
  end

  // Core read port: registered, returns pre-write contents on a same-cycle write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rvalid <= 1'b0;
      core_rdata  <= '0;
    end else begin
      core_rvalid <= core_en && core_rd_en;
      if (core_en && core_rd_en) core_rdata <= reg_value(core_ix);
    end
  end

`ifdef KMEANS_RF_PERF_CNT_EN
  // RUN cycle counter: cleared at start, saturating, frozen outside RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 perf_cnt <= '0;
    else if (go_accept)                         perf_cnt <= '0;
    else if (state == RUN_BUSY && perf_cnt != '1) perf_cnt <= perf_cnt + 32'd1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_kmeans_cfg_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kmeans_cfg_regfile
//  Brief    : Directed table-driven bench for kmeans_cfg_regfile plus
//             hand-written sequences for run/irq, RAM strobe, core port,
//             abort and asynchronous reset cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_kmeans_cfg_regfile;

  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 91;
  localparam int NUM_CENT = 8;
  localparam int MAN_W    = 16;
  localparam int IDX_W    = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] paddr = '0;
  logic              psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [DATA_W-1:0] pwdata = '0;
  logic [DATA_W-1:0] prdata;
  logic              pready, pslverr;
  logic              core_done = 1'b0, core_rd_en = 1'b0, core_wr_en = 1'b0;
  logic [IDX_W-1:0]  core_idx = '0;
  logic [DATA_W-1:0] core_wdata = '0;
  logic [DATA_W-1:0] core_rdata;
  logic              core_rvalid, go_core, irq, ram_cs_n, ram_we_n;
  logic [ADDR_W-1:0] ram_addr, first_addr, last_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [MAN_W-1:0]  threshold;

  int   n_vec = 0;
  int   n_err = 0;
  logic go_resp;
  logic ram_resp;

  kmeans_cfg_regfile #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CENT(NUM_CENT),
    .MAN_W(MAN_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .core_done(core_done), .core_rd_en(core_rd_en),
    .core_wr_en(core_wr_en), .core_idx(core_idx), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_rvalid(core_rvalid), .go_core(go_core),
    .irq(irq), .ram_cs_n(ram_cs_n), .ram_we_n(ram_we_n), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .first_addr(first_addr), .last_addr(last_addr),
    .threshold(threshold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_err;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One APB transfer: setup, access, then wait (bounded) for pready
  task automatic apb_xfer(input logic [ADDR_W-1:0] a, input logic w,
                          input logic [DATA_W-1:0] d,
                          output logic [DATA_W-1:0] rd, output logic er,
                          output int waits);
    int cyc;
    bit done;
    @(negedge clk);
    paddr = a; pwrite = w; pwdata = d; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    cyc = 0; done = 1'b0; rd = '0; er = 1'b0; go_resp = 1'b0; ram_resp = 1'b1;
    while (!done && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (pready) begin
        done = 1'b1; rd = prdata; er = pslverr; go_resp = go_core; ram_resp = ram_cs_n;
      end
    end
    waits = cyc - 1;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL apb_timeout: addr %0h no pready within 10 cycles", a);
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_wr(input string name, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic exp_err);
    logic [DATA_W-1:0] rd; logic er; int waits;
    apb_xfer(a, 1'b1, d, rd, er, waits);
    check({name, "_err"}, DATA_W'(er), DATA_W'(exp_err));
  endtask

  task automatic apb_rd(input string name, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] exp, input logic exp_err);
    logic [DATA_W-1:0] rd; logic er; int waits;
    apb_xfer(a, 1'b0, '0, rd, er, waits);
    check({name, "_rdata"}, rd, exp);
    check({name, "_err"}, DATA_W'(er), DATA_W'(exp_err));
  endtask

  // Drive core request for one cycle, sample the registered response after it
  task automatic core_op(input logic rd, input logic wr, input logic [IDX_W-1:0] idx,
                         input logic [DATA_W-1:0] d, output logic v,
                         output logic [DATA_W-1:0] q);
    @(negedge clk);
    core_rd_en = rd; core_wr_en = wr; core_idx = idx; core_wdata = d;
    @(negedge clk);
    v = core_rvalid; q = core_rdata;
    core_rd_en = 1'b0; core_wr_en = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk); core_done = 1'b1;
    @(negedge clk); core_done = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [DATA_W-1:0] rd, q;
    logic er, v;
    int waits;
    logic [DATA_W-1:0] ones;
    ones = '1;

    vecs[0]  = '{9'd11,  1'b1, 91'h5A5,   91'h0,     1'b0};
    vecs[1]  = '{9'd11,  1'b0, 91'h0,     91'h5A5,   1'b0};
    vecs[2]  = '{9'h1F0, 1'b1, 91'h1,     91'h0,     1'b1};
    vecs[3]  = '{9'd0,   1'b1, 91'h7,     91'h0,     1'b1};
    vecs[4]  = '{9'd0,   1'b0, 91'h0,     91'h0,     1'b0};
    vecs[5]  = '{9'd2,   1'b1, 91'h12,    91'h0,     1'b0};
    vecs[6]  = '{9'd2,   1'b0, 91'h0,     91'h12,    1'b0};
    vecs[7]  = '{9'd4,   1'b1, 91'h1AB,   91'h0,     1'b0};
    vecs[8]  = '{9'd4,   1'b0, 91'h0,     91'h1AB,   1'b0};
    vecs[9]  = '{9'd5,   1'b1, 91'h0FF,   91'h0,     1'b0};
    vecs[10] = '{9'd6,   1'b1, 91'h12345, 91'h0,     1'b0};
    vecs[11] = '{9'd6,   1'b0, 91'h0,     91'h2345,  1'b0};
    vecs[12] = '{9'd1,   1'b0, 91'h0,     91'h0,     1'b0};
    vecs[13] = '{9'd7,   1'b0, 91'h0,     91'h0,     1'b0};
`ifdef KMEANS_RF_PERF_CNT_EN
    vecs[14] = '{9'd16,  1'b0, 91'h0,     91'h0,     1'b0};
`else
    vecs[14] = '{9'd16,  1'b0, 91'h0,     91'h0,     1'b1};
`endif
    vecs[15] = '{9'd15,  1'b1, ones,      91'h0,     1'b0};
    vecs[16] = '{9'd15,  1'b0, 91'h0,     ones,      1'b0};
    vecs[17] = '{9'h100, 1'b0, 91'h0,     91'h0,     1'b1};
    vecs[18] = '{9'd1,   1'b1, 91'h0,     91'h0,     1'b0};
    vecs[19] = '{9'd0,   1'b0, 91'h0,     91'h0,     1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pready",   DATA_W'(pready),   0);
    check("rst_pslverr",  DATA_W'(pslverr),  0);
    check("rst_prdata",   prdata,            0);
    check("rst_go_core",  DATA_W'(go_core),  0);
    check("rst_irq",      DATA_W'(irq),      0);
    check("rst_rvalid",   DATA_W'(core_rvalid), 0);
    check("rst_ram_cs_n", DATA_W'(ram_cs_n), 1);
    check("rst_ram_we_n", DATA_W'(ram_we_n), 1);
    rst_n = 1'b1;

    // Table of IDLE-state register accesses
    for (int i = 0; i < 20; i++) begin
      apb_xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, rd, er, waits);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), DATA_W'(er), DATA_W'(vecs[i].exp_err));
      check($sformatf("vec%0d_waits", i), DATA_W'(waits), 1);
    end
    check("out_threshold",  DATA_W'(threshold),  91'h2345);
    check("out_first_addr", DATA_W'(first_addr), 91'h1AB);
    check("out_last_addr",  DATA_W'(last_addr),  91'h0FF);
    check("out_ram_addr",   DATA_W'(ram_addr),   91'h12);
    check("no_go_ctrl0",    DATA_W'(go_core),    0);

    // Aborted transfer: psel drops in WAIT, write must not land
    @(negedge clk);
    paddr = 9'd10; pwrite = 1'b1; pwdata = 91'h33; psel = 1'b1; penable = 1'b0;
    @(negedge clk); penable = 1'b1;
    @(negedge clk);
    check("abort_wait_pready", DATA_W'(pready), 0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk); check("abort_pready1", DATA_W'(pready), 0);
    @(negedge clk); check("abort_pready2", DATA_W'(pready), 0);
    apb_rd("abort_cent2", 9'd10, 91'h0, 1'b0);

    // RAM write strobe: low only in the cycle after RESP
    apb_wr("ram_data_wr", 9'd3, 91'h77, 1'b0);
    check("ram_cs_resp", DATA_W'(ram_resp), 1);
    @(negedge clk);
    check("ram_cs_n_low",  DATA_W'(ram_cs_n), 0);
    check("ram_we_n_low",  DATA_W'(ram_we_n), 0);
    check("ram_addr_val",  DATA_W'(ram_addr), 91'h12);
    check("ram_wdata_val", ram_wdata,         91'h77);
    @(negedge clk);
    check("ram_cs_n_high", DATA_W'(ram_cs_n), 1);
    check("ram_we_n_high", DATA_W'(ram_we_n), 1);

    // Core port ignored in IDLE
    core_op(1'b1, 1'b1, 5'd8, 91'hDEAD, v, q);
    check("core_idle_rvalid", DATA_W'(v), 0);
    apb_rd("core_idle_cent0", 9'd8, 91'h0, 1'b0);

    // GO: one-cycle start pulse, RUN visible in STATUS
    apb_wr("go_wr", 9'd1, 91'h1, 1'b0);
    check("go_core_pulse", DATA_W'(go_resp), 1);
    @(negedge clk);
    check("go_core_drop", DATA_W'(go_core), 0);
    apb_rd("status_run", 9'd0, 91'h1, 1'b0);
    apb_wr("thresh_run_wr", 9'd6, 91'h1, 1'b1);
    apb_rd("thresh_run_rd", 9'd6, 91'h2345, 1'b0);
    apb_wr("ram_run_wr", 9'd3, 91'h99, 1'b1);
    @(negedge clk);
    check("ram_run_no_strobe", DATA_W'(ram_cs_n), 1);
    apb_wr("go_run_wr", 9'd1, 91'h1, 1'b1);

    // Core port in RUN
    core_op(1'b0, 1'b1, 5'd9, 91'hABC, v, q);
    apb_rd("core_wr_cent1", 9'd9, 91'hABC, 1'b0);
    core_op(1'b1, 1'b0, 5'd11, 91'h0, v, q);
    check("core_rd_valid", DATA_W'(v), 1);
    check("core_rd_cent3", q, 91'h5A5);
    core_op(1'b1, 1'b1, 5'd11, 91'h111, v, q);
    check("core_rdwr_old", q, 91'h5A5);
    apb_rd("core_rdwr_new", 9'd11, 91'h111, 1'b0);
    core_op(1'b1, 1'b0, 5'd30, 91'h0, v, q);
    check("core_rd_unmapped_v", DATA_W'(v), 1);
    check("core_rd_unmapped",   q,          91'h0);
    core_op(1'b1, 1'b0, 5'd6, 91'h0, v, q);
    check("core_rd_thresh", q, 91'h2345);
    core_op(1'b0, 1'b1, 5'd6, 91'h5555, v, q);
    apb_rd("core_wr_thresh_ign", 9'd6, 91'h2345, 1'b0);

    // Done: irq raised, DONE behaviour, W1C back to IDLE
    check("irq_before_done", DATA_W'(irq), 0);
    pulse_done();
    check("irq_set", DATA_W'(irq), 1);
    apb_rd("status_done", 9'd0, 91'h6, 1'b0);
    apb_rd("irq_reg_done", 9'd7, 91'h1, 1'b0);
    apb_wr("go_done_wr", 9'd1, 91'h1, 1'b1);
    core_op(1'b1, 1'b1, 5'd8, 91'h55, v, q);
    check("core_done_rvalid", DATA_W'(v), 0);
    pulse_done();
    apb_rd("status_done2", 9'd0, 91'h6, 1'b0);
    apb_wr("irq_w0", 9'd7, 91'h0, 1'b0);
    check("irq_w0_keep", DATA_W'(irq), 1);
    apb_wr("irq_w1c", 9'd7, 91'h1, 1'b0);
    check("irq_clear", DATA_W'(irq), 0);
    apb_rd("status_idle", 9'd0, 91'h0, 1'b0);
    apb_rd("cent0_untouched", 9'd8, 91'h0, 1'b0);
    pulse_done();
    check("done_idle_ignored", DATA_W'(irq), 0);
    apb_rd("status_idle2", 9'd0, 91'h0, 1'b0);

`ifdef KMEANS_RF_PERF_CNT_EN
    // PERF: exactly 40 cycles spent in RUN
    apb_wr("perf_go", 9'd1, 91'h1, 1'b0);
    repeat (39) @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    apb_rd("perf_40", 9'd16, 91'd40, 1'b0);
    apb_wr("perf_ro", 9'd16, 91'h1, 1'b1);
    apb_rd("perf_frozen", 9'd16, 91'd40, 1'b0);
    apb_wr("perf_irq_clr", 9'd7, 91'h1, 1'b0);
`endif

    // Asynchronous reset mid-run while the APB slave sits in WAIT
    apb_wr("rst_go", 9'd1, 91'h1, 1'b0);
    @(negedge clk);
    paddr = 9'd0; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge clk); penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_pready",    DATA_W'(pready),     0);
    check("arst_pslverr",   DATA_W'(pslverr),    0);
    check("arst_prdata",    prdata,              0);
    check("arst_irq",       DATA_W'(irq),        0);
    check("arst_go_core",   DATA_W'(go_core),    0);
    check("arst_rvalid",    DATA_W'(core_rvalid), 0);
    check("arst_ram_cs_n",  DATA_W'(ram_cs_n),   1);
    check("arst_ram_we_n",  DATA_W'(ram_we_n),   1);
    check("arst_threshold", DATA_W'(threshold),  0);
    check("arst_first",     DATA_W'(first_addr), 0);
    check("arst_ram_wdata", ram_wdata,           0);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apb_xfer(9'd0, 1'b0, '0, rd, er, waits);
    check("post_rst_status", rd, 0);
    check("post_rst_waits",  DATA_W'(waits), 1);
    check("post_rst_err",    DATA_W'(er), 0);
    apb_rd("post_rst_cent3", 9'd11, 91'h0, 1'b0);
    apb_wr("post_rst_thr_wr", 9'd6, 91'hBEEF, 1'b0);
    apb_rd("post_rst_thr_rd", 9'd6, 91'hBEEF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
